seq_chk_lock: RTL

//  Downstream consumer of the NAND-feedback shift-register pulse generator. Samples its serial output and

---
 rtl/seq_chk_pkg.sv | 7 +
 rtl/seq_chk_hist.sv | 22 ++
 rtl/seq_chk_lock.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: shared state encoding and defaults for the pulse-stream lock checker
package seq_chk_pkg;
    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;
    localparam int         DEF_HIST_W = 4;
    localparam logic [3:0] DEF_TAPS   = 4'b1101;
    localparam int         PERIOD_W   = 8;
endpackage

// File: rtl/seq_chk_hist.sv
// seq_chk_hist: local copy of the generator history and NAND next-bit predictor
module seq_chk_hist
    import seq_chk_pkg::*;
#(
    parameter int                HIST_W = DEF_HIST_W,
    parameter logic [HIST_W-1:0] TAPS   = DEF_TAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_valid,
    output logic [HIST_W-1:0] hist,
    output logic              pred
);
    // untapped bits are forced high so they drop out of the NAND
    assign pred = ~&(hist | ~TAPS);

    // every valid bit enters the history, right or wrong, so the copy resynchronises itself
    always_ff @(posedge clk or negedge rst)
        if (!rst) hist <= '0;
        else if (din_valid) hist <= {hist[HIST_W-2:0], din};
endmodule

// File: rtl/seq_chk_lock.sv
// seq_chk_lock: predicts the pulse stream, declares lock and counts bit errors (option: SEQ_CHK_PERIOD_EN)
module seq_chk_lock
    import seq_chk_pkg::*;
#(
    parameter int                HIST_W   = DEF_HIST_W,
    parameter logic [HIST_W-1:0] TAPS     = DEF_TAPS,
    parameter int                LOCK_CNT = 8,
    parameter int                MISS_MAX = 3,
    parameter int                CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    input  logic                din_valid,
    input  logic                clr_err,
    output logic                locked,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    err_count,
    output logic [PERIOD_W-1:0] period
);
    localparam int             FW       = $clog2(HIST_W + 1);
    localparam logic [FW-1:0]  FILL_END = FW'(HIST_W);
    localparam logic [7:0]     RUN_END  = 8'(LOCK_CNT);
    localparam logic [3:0]     MISS_END = 4'(MISS_MAX);

    state_t        state;
    logic [FW-1:0] fill;
    logic [7:0]    run;
    logic [3:0]    miss;
    logic          pred, bad, to_lock, leave;

`ifdef SEQ_CHK_PERIOD_EN
    logic [HIST_W-1:0]   hist, nh, snap;
    logic [PERIOD_W-1:0] pcnt, pcnt_n;

    seq_chk_hist #(.HIST_W(HIST_W), .TAPS(TAPS)) u_hist (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .hist(hist), .pred(pred)
    );

    assign nh     = {hist[HIST_W-2:0], din};
    assign pcnt_n = &pcnt ? pcnt : pcnt + 1'b1;

    // snapshot the history on lock entry; each return to it closes one measured period
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            snap   <= '0;
            pcnt   <= '0;
            period <= '0;
        end else if (din_valid) begin
            if (to_lock) begin
                snap <= nh;
                pcnt <= '0;
            end else if (leave) period <= '0;
            else if (state == LOCK) begin
                pcnt <= nh == snap ? '0 : pcnt_n;
                if (nh == snap) period <= pcnt_n;
            end
        end
`else
    seq_chk_hist #(.HIST_W(HIST_W), .TAPS(TAPS)) u_hist (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .hist(), .pred(pred)
    );

    assign period = '0;
`endif

    assign bad     = din != pred;
    assign to_lock = state == SYNC && !bad && run + 8'd1 == RUN_END;
    assign leave   = state == LOCK && bad && miss + 4'd1 == MISS_END;
    assign locked  = state == LOCK;

    // error strobe and saturating count; a same-cycle clear beats the increment
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= din_valid && state == LOCK && bad;
            if (clr_err) err_count <= '0;
            else if (din_valid && state == LOCK && bad && !(&err_count)) err_count <= err_count + 1'b1;
        end

    // HUNT fills the history, SYNC demands a clean run, LOCK tolerates isolated misses
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= HUNT;
            fill  <= '0;
            run   <= '0;
            miss  <= '0;
        end else if (din_valid) begin
            if (state == HUNT) begin
                fill <= fill + 1'b1;
                if (fill + 1'b1 == FILL_END) begin
                    state <= SYNC;
                    run   <= '0;
                end
            end else if (state == SYNC) begin
                run <= bad ? '0 : run + 1'b1;
                if (to_lock) begin
                    state <= LOCK;
                    miss  <= '0;
                end
            end else if (state == LOCK) begin
                miss <= bad ? miss + 1'b1 : '0;
                if (leave) begin
                    state <= HUNT;
                    fill  <= '0;
                end
            end else state <= HUNT;
        end
endmodule
